// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
// Optional round-robin tie-break is enabled with `define DM_ARB_ROUND_ROBIN_EN.
package dm_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  localparam int unsigned RD_LAT_MAX = 4;
  localparam int unsigned WCNT_W     = $clog2(RD_LAT_MAX);

  // Reads must never drive byte enables, whatever the requester left on wea.
  function automatic logic [3:0] issue_wea(input logic we, input logic [3:0] wea);
    return we ? wea : 4'b0000;
  endfunction

endpackage

// File: rtl/dm_arb_pick.sv
// Combinational 2-way request picker for the data-memory arbiter.
// DM_ARB_ROUND_ROBIN_EN selects round-robin ties; otherwise port 0 has fixed priority.
module dm_arb_pick
  import dm_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       win_o,
  output logic       valid_o
);

  always_comb begin
    valid_o = |req_i;
`ifdef DM_ARB_ROUND_ROBIN_EN
    if (&req_i) begin
      win_o = ~last_i;
    end else begin
      win_o = req_i[1] ? PORT_DBG : PORT_CPU;
    end
`else
    win_o = req_i[0] ? PORT_CPU : PORT_DBG;
`endif
  end

`ifndef DM_ARB_ROUND_ROBIN_EN
  logic unused_last;
  assign unused_last = last_i;
`endif

endmodule

// File: rtl/dm_port_arbiter.sv
// Two-port arbiter in front of the single data-memory BRAM (CPU port 0, debug port 1).
// Define DM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking instead of port-0 priority.
module dm_port_arbiter
  import dm_arb_pkg::*;
#(
  parameter int unsigned AW     = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [3:0]    m0_wea,
  input  logic [31:0]   m0_wdata,
  output logic          m0_ack,
  output logic [31:0]   m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [3:0]    m1_wea,
  input  logic [31:0]   m1_wdata,
  output logic          m1_ack,
  output logic [31:0]   m1_rdata,
  output logic          mem_en,
  output logic [AW-1:0] mem_addr,
  output logic [3:0]    mem_wea,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic          busy
);

  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(RD_LAT - 1);

  state_e            state_q, state_d;
  logic              port_q, port_d;
  logic              we_q, we_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [3:0]        wea_q, wea_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata0_q, rdata0_d;
  logic [31:0]       rdata1_q, rdata1_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;

  logic pick_win;
  logic pick_valid;
  logic pick_last;

`ifdef DM_ARB_ROUND_ROBIN_EN
  logic last_q, last_d;
  assign pick_last = last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= PORT_DBG;
    end else begin
      last_q <= last_d;
    end
  end
`else
  assign pick_last = PORT_DBG;
`endif

  dm_arb_pick u_pick (
    .req_i   ({m1_req, m0_req}),
    .last_i  (pick_last),
    .win_o   (pick_win),
    .valid_o (pick_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      port_q   <= PORT_CPU;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wea_q    <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      wcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      port_q   <= port_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wea_q    <= wea_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      wcnt_q   <= wcnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    port_d   = port_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wea_d    = wea_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    wcnt_d   = wcnt_q;
`ifdef DM_ARB_ROUND_ROBIN_EN
    last_d   = last_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          port_d = pick_win;
          if (pick_win == PORT_DBG) begin
            we_d    = m1_we;
            addr_d  = m1_addr;
            wea_d   = m1_wea;
            wdata_d = m1_wdata;
          end else begin
            we_d    = m0_we;
            addr_d  = m0_addr;
            wea_d   = m0_wea;
            wdata_d = m0_wdata;
          end
`ifdef DM_ARB_ROUND_ROBIN_EN
          last_d = pick_win;
`endif
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wcnt_d  = '0;
        state_d = we_q ? ST_DONE : ST_WAIT;
      end
      ST_WAIT: begin
        // mem_rdata is valid only in the final WAIT cycle.
        if (wcnt_q == WCNT_LAST) begin
          if (port_q == PORT_DBG) begin
            rdata1_d = mem_rdata;
          end else begin
            rdata0_d = mem_rdata;
          end
          wcnt_d  = '0;
          state_d = ST_DONE;
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign mem_en    = (state_q == ST_ISSUE);
  assign mem_wea   = (state_q == ST_ISSUE) ? issue_wea(we_q, wea_q) : 4'b0000;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign m0_ack    = (state_q == ST_DONE) && (port_q == PORT_CPU);
  assign m1_ack    = (state_q == ST_DONE) && (port_q == PORT_DBG);
  assign m0_rdata  = rdata0_q;
  assign m1_rdata  = rdata1_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Scoreboard bench for dm_port_arbiter: one instance with RD_LAT=1, one with RD_LAT=3.
// Tie-order expectations follow DM_ARB_ROUND_ROBIN_EN when it is defined.
module tb_dm_port_arbiter;

  typedef struct {
    int          port;
    int          cyc;
    bit          rd;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_tests = 0;
  int n_fail  = 0;

  logic        req   [2][2];
  logic        we    [2][2];
  logic [31:0] addr  [2][2];
  logic [3:0]  wea   [2][2];
  logic [31:0] wdata [2][2];
  logic        ack   [2][2];
  logic [31:0] rdata [2][2];

  logic        mem_en    [2];
  logic [31:0] mem_addr  [2];
  logic [3:0]  mem_wea   [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];
  logic        busy      [2];

  logic [31:0] refm [2][256];
  exp_t        sbq0 [$];
  exp_t        sbq1 [$];

  function automatic logic [31:0] pat(input int i);
    return 32'hA500_0000 ^ (32'(i) * 32'h0001_0203);
  endfunction

  function automatic int lat(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int unsigned L = (g == 0) ? 1 : 3;

    dm_port_arbiter #(.AW(32), .RD_LAT(L)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .m0_req    (req[g][0]),
      .m0_we     (we[g][0]),
      .m0_addr   (addr[g][0]),
      .m0_wea    (wea[g][0]),
      .m0_wdata  (wdata[g][0]),
      .m0_ack    (ack[g][0]),
      .m0_rdata  (rdata[g][0]),
      .m1_req    (req[g][1]),
      .m1_we     (we[g][1]),
      .m1_addr   (addr[g][1]),
      .m1_wea    (wea[g][1]),
      .m1_wdata  (wdata[g][1]),
      .m1_ack    (ack[g][1]),
      .m1_rdata  (rdata[g][1]),
      .mem_en    (mem_en[g]),
      .mem_addr  (mem_addr[g]),
      .mem_wea   (mem_wea[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_rdata (mem_rdata[g]),
      .busy      (busy[g])
    );

    // BRAM model: output pipeline carries a poison word when not enabled,
    // so capturing in the wrong cycle yields visibly wrong data.
    logic [31:0] ram  [256];
    logic [31:0] pipe [L];

    initial begin
      for (int i = 0; i < 256; i++) ram[i] = pat(i);
    end

    always @(posedge clk) begin
      if (mem_en[g]) begin
        pipe[0] <= ram[mem_addr[g][9:2]];
        for (int b = 0; b < 4; b++) begin
          if (mem_wea[g][b]) ram[mem_addr[g][9:2]][8*b +: 8] <= mem_wdata[g][8*b +: 8];
        end
      end else begin
        pipe[0] <= 32'hBAD0_BAD0;
      end
      for (int s = 1; s < int'(L); s++) pipe[s] <= pipe[s-1];
    end

    assign mem_rdata[g] = pipe[L-1];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_exp(input int inst, input int port, input int c, input bit rd,
                          input logic [31:0] d);
    exp_t e;
    e.port = port;
    e.cyc  = c;
    e.rd   = rd;
    e.data = d;
    if (inst == 0) sbq0.push_back(e);
    else           sbq1.push_back(e);
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    bit   have;
    for (int i = 0; i < 2; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (ack[i][p] === 1'b1) begin
          have = (i == 0) ? (sbq0.size() > 0) : (sbq1.size() > 0);
          if (!have) begin
            chk($sformatf("ack_unexpected i%0d p%0d", i, p), 32'(ack[i][p]), 32'd0);
          end else begin
            e = (i == 0) ? sbq0.pop_front() : sbq1.pop_front();
            chk($sformatf("ack_port i%0d", i), p, e.port);
            chk($sformatf("ack_cycle i%0d p%0d", i, p), cyc, e.cyc);
            if (e.rd) chk($sformatf("rdata i%0d p%0d", i, p), rdata[i][p], e.data);
          end
        end
      end
    end
  end

  task automatic chk_idle(input int i, input string ph);
    chk({ph, "_busy"},   32'(busy[i]),    32'd0);
    chk({ph, "_mem_en"}, 32'(mem_en[i]),  32'd0);
    chk({ph, "_mem_wea"}, 32'(mem_wea[i]), 32'd0);
    chk({ph, "_mem_addr"}, mem_addr[i],   32'd0);
    chk({ph, "_mem_wdata"}, mem_wdata[i], 32'd0);
    chk({ph, "_ack0"},   32'(ack[i][0]),  32'd0);
    chk({ph, "_ack1"},   32'(ack[i][1]),  32'd0);
    chk({ph, "_rdata0"}, rdata[i][0],     32'd0);
    chk({ph, "_rdata1"}, rdata[i][1],     32'd0);
  endtask

  task automatic do_access(input int inst, input int port, input bit w, input logic [31:0] a,
                           input logic [3:0] be, input logic [31:0] d);
    int          n;
    int          ack_c;
    int          en_cnt;
    int          wea_cnt;
    logic [3:0]  wea_iss;
    logic [31:0] addr_iss;
    logic [31:0] wd_iss;
    @(posedge clk); #1;
    req[inst][port]   = 1'b1;
    we[inst][port]    = w;
    addr[inst][port]  = a;
    wea[inst][port]   = be;
    wdata[inst][port] = d;
    n     = cyc;
    ack_c = w ? n + 2 : n + 2 + lat(inst);
    if (w) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) refm[inst][a[9:2]][8*b +: 8] = d[8*b +: 8];
      end
    end
    push_exp(inst, port, ack_c, !w, refm[inst][a[9:2]]);
    en_cnt   = 0;
    wea_cnt  = 0;
    wea_iss  = '0;
    addr_iss = '0;
    wd_iss   = '0;
    do begin
      @(negedge clk);
      if (mem_en[inst]) en_cnt++;
      if (mem_wea[inst] != 4'b0000) wea_cnt++;
      if (cyc == n + 1) begin
        wea_iss  = mem_wea[inst];
        addr_iss = mem_addr[inst];
        wd_iss   = mem_wdata[inst];
      end
    end while (cyc < ack_c);
    @(posedge clk); #1;
    req[inst][port] = 1'b0;
    chk($sformatf("en_cycles i%0d a%0h", inst, a), en_cnt, 1);
    chk($sformatf("issue_wea i%0d a%0h", inst, a), 32'(wea_iss), w ? 32'(be) : 32'd0);
    chk($sformatf("wea_cycles i%0d a%0h", inst, a), wea_cnt, (w && be != 4'b0000) ? 1 : 0);
    chk($sformatf("issue_addr i%0d", inst), addr_iss, a);
    if (w) chk($sformatf("issue_wdata i%0d", inst), wd_iss, d);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int n;
    for (int i = 0; i < 2; i++) begin
      for (int p = 0; p < 2; p++) begin
        req[i][p]   = 1'b0;
        we[i][p]    = 1'b0;
        addr[i][p]  = '0;
        wea[i][p]   = '0;
        wdata[i][p] = '0;
      end
      for (int k = 0; k < 256; k++) refm[i][k] = pat(k);
    end

    repeat (3) @(posedge clk);
    #1;
    chk_idle(0, "rst0");
    chk_idle(1, "rst1");
    rst = 1'b0;

    // Port 0 write then read-back, RD_LAT=1.
    do_access(0, 0, 1'b1, 32'h10, 4'b1111, 32'hDEAD_BEEF);
    do_access(0, 0, 1'b0, 32'h10, 4'b0000, 32'h0);

    // Port 1 read, RD_LAT=3.
    do_access(1, 1, 1'b0, 32'h20, 4'b0000, 32'h0);

    // Read with byte enables presented must not write.
    do_access(0, 0, 1'b0, 32'h10, 4'b1111, 32'h5555_5555);

    // Partial and empty byte-enable writes.
    do_access(0, 0, 1'b1, 32'h10, 4'b0100, 32'h1122_3344);
    chk("rdata_hold_after_write", rdata[0][0], 32'hDEAD_BEEF);
    do_access(0, 0, 1'b0, 32'h10, 4'b0000, 32'h0);
    do_access(0, 0, 1'b1, 32'h10, 4'b0000, 32'hFFFF_FFFF);
    do_access(0, 0, 1'b0, 32'h10, 4'b0000, 32'h0);

    // Unaligned address passes straight through.
    do_access(0, 1, 1'b1, 32'h23, 4'b0011, 32'hCAFE_0055);
    do_access(0, 1, 1'b0, 32'h23, 4'b0000, 32'h0);

    // Simultaneous reads, port 0 re-requests right after its first ack.
    @(posedge clk); #1;
    n = cyc;
    req[0][0] = 1'b1; we[0][0] = 1'b0; addr[0][0] = 32'h40;
    req[0][1] = 1'b1; we[0][1] = 1'b0; addr[0][1] = 32'h44;
    push_exp(0, 0, n + 3, 1'b1, refm[0][8'h10]);
`ifdef DM_ARB_ROUND_ROBIN_EN
    push_exp(0, 1, n + 7, 1'b1, refm[0][8'h11]);
    push_exp(0, 0, n + 11, 1'b1, refm[0][8'h12]);
`else
    push_exp(0, 0, n + 7, 1'b1, refm[0][8'h12]);
    push_exp(0, 1, n + 11, 1'b1, refm[0][8'h11]);
`endif
    wait_cyc(n + 4);
    addr[0][0] = 32'h48;
    wait_cyc(n + 8);
`ifdef DM_ARB_ROUND_ROBIN_EN
    req[0][1] = 1'b0;
`else
    req[0][0] = 1'b0;
`endif
    wait_cyc(n + 12);
    req[0][0] = 1'b0;
    req[0][1] = 1'b0;

    // Reset in the middle of a RD_LAT=3 read.
    @(posedge clk); #1;
    n = cyc;
    req[1][1] = 1'b1; we[1][1] = 1'b0; addr[1][1] = 32'h30;
    wait_cyc(n + 3);
    chk("busy_in_wait", 32'(busy[1]), 32'd1);
    rst = 1'b1;
    req[1][1] = 1'b0;
    #1;
    chk_idle(1, "midrst");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    do_access(1, 1, 1'b0, 32'h20, 4'b0000, 32'h0);

    repeat (5) @(posedge clk);
    #1;
    chk("sb_pending_i0", sbq0.size(), 0);
    chk("sb_pending_i1", sbq1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
